// File: rtl/obs_pkg.sv
// Shared constants and game-state encoding for the obstacle game.
// Used by the scheduler, the obstacle instances and the top level.
package obs_pkg;

  localparam int MAX_X        = 640;
  localparam int MAX_Y        = 480;
  localparam int FRAME_TICK_Y = 481;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  // Fold an LFSR sample into a left edge that keeps the whole obstacle on screen.
  function automatic logic [10:0] spawn_x1(input logic [9:0] l, input int obs_w);
    logic [10:0] lw;
    lw = {1'b0, l};
    if (lw < 11'(MAX_X - obs_w)) begin
      return lw;
    end else begin
      return lw - 11'd512;
    end
  endfunction

endpackage

// File: rtl/obs_scheduler_lfsr10.sv
// 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1, free-running every clock.
module lfsr10 (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] q
);

  logic [9:0] q_r;

  // Shift register with feedback from taps 10 and 7.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r <= 10'h001;
    end else begin
      q_r <= {q_r[8:0], q_r[9] ^ q_r[6]};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/obs_scheduler.sv
// Obstacle spawn scheduler: game FSM, slot allocation, and score/lives tracking
// driven by per-slot hit/escape reports from the obstacle instances.
module obs_scheduler
  import obs_pkg::*;
#(
  parameter int NSLOT        = 4,
  parameter int SPAWN_FRAMES = 60,
  parameter int OBS_W        = 40,
  parameter int LIVES        = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [10:0]            pix_x,
  input  logic [10:0]            pix_y,
  input  logic [NSLOT-1:0]       obs_state,
  input  logic [NSLOT-1:0]       crossed,
  output logic [NSLOT-1:0]       slot_rst,
  output logic [NSLOT-1:0]       slot_active,
  output logic [11*NSLOT-1:0]    slot_x1,
  output logic [11*NSLOT-1:0]    slot_x2,
  output logic [7:0]             score,
  output logic [1:0]             lives,
  output logic                   game_over
);

  localparam int CW = $clog2(SPAWN_FRAMES + 1);

  game_state_e      state_r, state_nx_s;
  logic             game_over_r;
  logic [9:0]       lfsr_s;
  logic             frame_tick_s, play_s, enter_play_s, spawn_s;
  logic [CW-1:0]    cnt_r, cnt_inc_s;
  logic [NSLOT-1:0] active_r, free_s, spawn_sel_s, hit_s, esc_s;
  logic [7:0]       score_r, hit_cnt_s, esc_cnt_s;
  logic [8:0]       score_sum_s;
  logic [7:0]       score_nx_s;
  logic [1:0]       lives_r, lives_nx_s;
  logic [10:0]      x1_s, x2_s;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_s)
  );

  assign frame_tick_s = (pix_y == 11'(FRAME_TICK_Y)) && (pix_x == 11'd0);
  assign play_s       = (state_r == ST_PLAY);
  assign free_s       = ~active_r;
  // Isolate the lowest clear bit of active_r: that is the lowest FREE slot.
  assign spawn_sel_s  = free_s & (active_r + {{(NSLOT-1){1'b0}}, 1'b1});
  assign cnt_inc_s    = (cnt_r == CW'(SPAWN_FRAMES)) ? cnt_r : cnt_r + CW'(1);
  assign spawn_s      = play_s && (state_nx_s == ST_PLAY) && frame_tick_s &&
                        (cnt_inc_s == CW'(SPAWN_FRAMES)) && (|free_s);
  assign x1_s         = spawn_x1(lfsr_s, OBS_W);
  assign x2_s         = x1_s + 11'(OBS_W - 1);

  // Count hits and escapes across all slots this cycle.
  always_comb begin
    hit_cnt_s = 8'd0;
    esc_cnt_s = 8'd0;
    for (int i = 0; i < NSLOT; i++) begin
      hit_cnt_s = hit_cnt_s + {7'd0, hit_s[i]};
      esc_cnt_s = esc_cnt_s + {7'd0, esc_s[i]};
    end
    score_sum_s = {1'b0, score_r} + {1'b0, hit_cnt_s};
    score_nx_s  = score_sum_s[8] ? 8'hFF : score_sum_s[7:0];
    if ({6'd0, lives_r} > esc_cnt_s) begin
      lives_nx_s = lives_r - esc_cnt_s[1:0];
    end else begin
      lives_nx_s = 2'd0;
    end
  end

  // Game FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: state_nx_s = start ? ST_PLAY : ST_IDLE;
      ST_PLAY: state_nx_s = (lives_nx_s == 2'd0) ? ST_OVER : ST_PLAY;
      ST_OVER: state_nx_s = start ? ST_PLAY : ST_OVER;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  assign enter_play_s = (state_r != ST_PLAY) && (state_nx_s == ST_PLAY);

  // Game FSM state register and registered game_over flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      game_over_r <= (state_nx_s == ST_OVER);
    end
  end

  // Slot occupancy, spawn counter, score and lives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_r <= '0;
      cnt_r    <= '0;
      score_r  <= 8'd0;
      lives_r  <= 2'(LIVES);
    end else if (enter_play_s) begin
      active_r <= '0;
      cnt_r    <= '0;
      score_r  <= 8'd0;
      lives_r  <= 2'(LIVES);
    end else if (play_s) begin
      score_r <= score_nx_s;
      lives_r <= lives_nx_s;
      if (state_nx_s == ST_OVER) begin
        active_r <= '0;
      end else begin
        active_r <= (active_r & ~(hit_s | esc_s)) | (spawn_s ? spawn_sel_s : '0);
      end
      if (frame_tick_s) begin
        cnt_r <= spawn_s ? '0 : cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      active_r <= '0;
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    logic [10:0] x1_r, x2_r;

    // A hit takes precedence over a crossing in the same cycle.
    assign hit_s[g] = play_s & active_r[g] & ~obs_state[g];
    assign esc_s[g] = play_s & active_r[g] & obs_state[g] & crossed[g];

    // Latch the obstacle edges on the spawning edge only.
    always_ff @(posedge clk) begin
      if (!reset) begin
        x1_r <= 11'd0;
        x2_r <= 11'd0;
      end else if (spawn_s && spawn_sel_s[g]) begin
        x1_r <= x1_s;
        x2_r <= x2_s;
      end else begin
        x1_r <= x1_r;
        x2_r <= x2_r;
      end
    end

    assign slot_x1[11*g +: 11] = x1_r;
    assign slot_x2[11*g +: 11] = x2_r;
  end

  assign slot_active = active_r;
  assign slot_rst    = ~active_r;
  assign score       = score_r;
  assign lives       = lives_r;
  assign game_over   = game_over_r;

endmodule
